// File: rtl/write_burst_scheduler.sv
// Write burst scheduler: chops a frame (or each line) of video into AXI
// write bursts, gates each request on FIFO fill level and tracks the byte
// offset of every burst from the frame base.
module write_burst_scheduler #(
    parameter int    NOR_BURST_LEN = 200,
    parameter string MODE          = "ONCE",
    parameter int    AXI_DSIZE     = 256,
    parameter int    DSIZE         = 24,
    parameter int    LSIZE         = 9
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             fsync,
    input  logic [15:0]      fifo_count,
    input  logic             burst_ack,
    input  logic             burst_done,
    output logic             burst_req,
    output logic [LSIZE-1:0] burst_len,
    output logic [31:0]      burst_addr,
    output logic             frame_done,
    output logic             busy
);

    localparam bit LINE_MODE      = (MODE == "LINE");
    localparam int BEAT_SHIFT     = $clog2(AXI_DSIZE);
    localparam int BYTES_PER_BEAT = AXI_DSIZE / 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DATA,
        REQ,
        BUSY,
        FINISH
    } state_t;

    state_t      state;
    logic [31:0] pix_r;
    logic [47:0] unit_bits;
    logic [39:0] unit_beats;
    logic [39:0] remaining;
    logic [15:0] line_cnt;
    logic [31:0] addr;

    logic [LSIZE-1:0] next_len;
    logic [39:0]      rem_after;
    logic             fifo_ok;
    logic             last_unit;

    // Pixel count of one budget unit (line or whole frame).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            pix_r <= '0;
        else if (LINE_MODE)
            pix_r <= {16'd0, hactive};
        else
            pix_r <= 32'(vactive) * 32'(hactive);
    end

    assign unit_bits = 48'(pix_r) * 48'(DSIZE);

    // Beats per unit, rounded up to whole AXI words (AXI_DSIZE is a power of 2).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            unit_beats <= '0;
        else
            unit_beats <= 40'((unit_bits + 48'(AXI_DSIZE - 1)) >> BEAT_SHIFT);
    end

    // Next burst size and the decisions derived from it.
    always_comb begin
        next_len = LSIZE'(NOR_BURST_LEN);
        if (remaining < 40'(NOR_BURST_LEN))
            next_len = LSIZE'(remaining);
        rem_after = remaining - 40'(burst_len);
        fifo_ok   = (40'(fifo_count) >= 40'(next_len));
        last_unit = !LINE_MODE || ((line_cnt + 16'd1) == vactive);
    end

    // Burst sequencing FSM; fsync restarts the frame from any state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            line_cnt   <= '0;
            addr       <= '0;
            burst_req  <= 1'b0;
            burst_len  <= '0;
            burst_addr <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fsync) begin
                state     <= LOAD;
                burst_req <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        remaining <= unit_beats;
                        line_cnt  <= '0;
                        addr      <= '0;
                        // Empty frame still reports completion, with no bursts.
                        if (unit_beats == '0 || (LINE_MODE && vactive == 16'd0)) begin
                            state      <= FINISH;
                            frame_done <= 1'b1;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                    WAIT_DATA: begin
                        if (fifo_ok) begin
                            burst_len  <= next_len;
                            burst_addr <= addr;
                            burst_req  <= 1'b1;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (burst_ack) begin
                            burst_req <= 1'b0;
                            state     <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (burst_done) begin
                            remaining <= rem_after;
                            addr      <= addr + 32'(burst_len) * 32'(BYTES_PER_BEAT);
                            if (rem_after == '0) begin
                                if (last_unit) begin
                                    state      <= FINISH;
                                    frame_done <= 1'b1;
                                end else begin
                                    // Next line: fresh budget, address keeps running.
                                    remaining <= unit_beats;
                                    line_cnt  <= line_cnt + 16'd1;
                                    state     <= WAIT_DATA;
                                end
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
